// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: issues one AXI-style read per core PC and holds the
// returned 32-bit instruction (or a fetch fault) until the core consumes it.
module ifu_fetch #(
    parameter int ADDR_W = 64,
    parameter int BUS_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_fault,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [BUS_W-1:0]  mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BUS_W / 8 - 1));

    logic [1:0]  state;
    logic        drop;
    logic        pc_hi_word;
    logic [31:0] rword;

    // Only pc[2] of the latched pc is needed after the request: it picks the
    // instruction half of a 64-bit beat. The rest already lives in mem_araddr.
    if (BUS_W == 64) begin : g_bus64
        assign rword = pc_hi_word ? mem_rdata[63:32] : mem_rdata[31:0];
    end else begin : g_bus32
        assign rword = mem_rdata[31:0];
    end

    assign busy       = (state != S_IDLE);
    assign mem_rready = (state == S_DATA);

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            inst        <= '0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            mem_araddr  <= '0;
            mem_arvalid <= 1'b0;
            drop        <= 1'b0;
            pc_hi_word  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pc_valid && !flush) begin
                        pc_hi_word <= pc[2];
                        if (pc[1:0] != 2'b00) begin
                            inst        <= '0;
                            fetch_fault <= 1'b1;
                            inst_valid  <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            mem_araddr  <= pc & ALIGN_MASK;
                            mem_arvalid <= 1'b1;
                            state       <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // The address phase must complete even when flushed; the
                    // response is discarded later instead.
                    if (flush) drop <= 1'b1;
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_rvalid) begin
                        drop <= 1'b0;
                        if (drop || flush) begin
                            state <= S_IDLE;
                        end else begin
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                            if (mem_rresp != 2'b00) begin
                                fetch_fault <= 1'b1;
                                inst        <= '0;
                            end else begin
                                inst <= rword;
                            end
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready || flush) begin
                        inst_valid  <= 1'b0;
                        fetch_fault <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed fetches push expected results, a
// monitor compares them when inst_valid rises; a bus responder models delays.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [63:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_fault;
    logic [63:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid;
    logic        mem_rready;
    logic        busy;

    ifu_fetch #(.ADDR_W(64), .BUS_W(64)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .fetch_fault(fetch_fault), .mem_araddr(mem_araddr),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready), .busy(busy)
    );

    typedef struct {
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Bus responder configuration, set by the driver before each request.
    logic        resp_en = 1'b1;
    logic [63:0] exp_araddr = '0;
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [63:0] bus_data = '0;
    logic [1:0]  bus_resp = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: compares each new presentation against the scoreboard.
    initial begin
        logic        iv_prev = 1'b0;
        logic [31:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (inst_valid && !iv_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_inst_valid: got inst %h fault %b, required no output",
                             inst, fetch_fault);
                end else begin
                    e = sb.pop_front();
                    check("inst", {32'b0, inst}, {32'b0, e.inst});
                    check("fault", {63'b0, fetch_fault}, {63'b0, e.fault});
                end
                held = inst;
            end else if (inst_valid) begin
                check("inst_stable", {32'b0, inst}, {32'b0, held});
            end
            iv_prev = inst_valid;
        end
    end

    // Bus responder: checks the address, holds arready off for ar_delay
    // cycles, then returns one beat after r_delay cycles.
    initial begin
        logic [63:0] addr_seen;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rresp   = '0;
        forever begin
            @(negedge clk);
            if (resp_en && mem_arvalid && !rst) begin
                check("araddr", mem_araddr, exp_araddr);
                addr_seen = mem_araddr;
                for (int i = 0; i < ar_delay; i++) begin
                    @(negedge clk);
                    check("arvalid_held", {63'b0, mem_arvalid}, 64'd1);
                    check("araddr_held", mem_araddr, addr_seen);
                end
                mem_arready = 1'b1;
                @(negedge clk);
                mem_arready = 1'b0;
                repeat (r_delay) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = bus_data;
                mem_rresp  = bus_resp;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                mem_rresp  = '0;
            end
        end
    end

    task automatic set_bus(input logic [63:0] ea, input int ard, input int rd,
                           input logic [63:0] data, input logic [1:0] resp);
        exp_araddr = ea;
        ar_delay   = ard;
        r_delay    = rd;
        bus_data   = data;
        bus_resp   = resp;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'b0, busy}, 64'd0);
    endtask

    // One complete fetch; exp_lat = 0 skips the latency check.
    task automatic fetch(input logic [63:0] a, input logic [63:0] ea, input int ard,
                         input int rd, input logic [63:0] data, input logic [1:0] resp,
                         input logic [31:0] ei, input logic ef, input int hold,
                         input int exp_lat);
        int lat;
        set_bus(ea, ard, rd, data, resp);
        sb.push_back('{ei, ef});
        pc       = a;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        pc       = 64'h0000_dead_beef_0000;
        lat      = 1;
        if (a[1:0] != 2'b00) check("misaligned_no_arvalid", {63'b0, mem_arvalid}, 64'd0);
        while (!inst_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (exp_lat != 0) check("latency", 64'(lat), 64'(exp_lat));
        else              check("valid_seen", {63'b0, inst_valid}, 64'd1);
        repeat (hold) begin
            @(negedge clk);
            check("valid_held", {63'b0, inst_valid}, 64'd1);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("valid_clear", {63'b0, inst_valid}, 64'd0);
        check("fault_clear", {63'b0, fetch_fault}, 64'd0);
        check("busy_after_retire", {63'b0, busy}, 64'd0);
    endtask

    // A fetch that is presented and then flushed out of HOLD.
    task automatic flush_hold(input logic with_ready);
        int n = 0;
        set_bus(64'h8000_0000, 0, 0, 64'h00100093_00000413, 2'b00);
        sb.push_back('{32'h0000_0413, 1'b0});
        pc       = 64'h8000_0000;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        while (!inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", {63'b0, inst_valid}, 64'd1);
        flush      = 1'b1;
        inst_ready = with_ready;
        @(negedge clk);
        flush      = 1'b0;
        inst_ready = 1'b0;
        check("hold_flush_valid", {63'b0, inst_valid}, 64'd0);
        check("hold_flush_busy", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        pc         = '0;
        pc_valid   = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_inst", {32'b0, inst}, 64'd0);
        check("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        check("rst_fault", {63'b0, fetch_fault}, 64'd0);
        check("rst_araddr", mem_araddr, 64'd0);
        check("rst_arvalid", {63'b0, mem_arvalid}, 64'd0);
        check("rst_rready", {63'b0, mem_rready}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait fetch of the lower half, held two cycles before retire.
        fetch(64'h8000_0000, 64'h8000_0000, 0, 0, 64'h00100093_00000413, 2'b00,
              32'h0000_0413, 1'b0, 2, 3);
        // Upper half with address and data stalls.
        fetch(64'h8000_0004, 64'h8000_0000, 3, 2, 64'h00100093_00000413, 2'b00,
              32'h0010_0093, 1'b0, 0, 0);
        // Misaligned pc faults without touching the bus.
        fetch(64'h8000_0002, 64'h0, 0, 0, 64'h0, 2'b00, 32'h0, 1'b1, 1, 1);
        // Bus error zeroes the instruction and raises the fault.
        fetch(64'h8000_000C, 64'h8000_0008, 1, 1, 64'hffff_ffff_ffff_ffff, 2'b10,
              32'h0, 1'b1, 1, 0);

        // Flush in IDLE blocks the request.
        pc       = 64'h8000_0000;
        pc_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        flush    = 1'b0;
        check("idle_flush_busy", {63'b0, busy}, 64'd0);
        check("idle_flush_arvalid", {63'b0, mem_arvalid}, 64'd0);

        // Flush in ADDR: address handshake still completes, data discarded.
        set_bus(64'h8000_0000, 2, 0, 64'h00100093_00000413, 2'b00);
        pc       = 64'h8000_0000;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        flush    = 1'b1;
        check("addr_flush_arvalid", {63'b0, mem_arvalid}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        check("addr_flush_arvalid_kept", {63'b0, mem_arvalid}, 64'd1);
        wait_idle("addr_flush_idle");

        // Flush in DATA before the response arrives.
        set_bus(64'h8000_0000, 0, 3, 64'h00100093_00000413, 2'b00);
        pc       = 64'h8000_0000;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        n = 0;
        while (!mem_rready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("data_reached", {63'b0, mem_rready}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle("data_flush_idle");

        flush_hold(1'b0);
        flush_hold(1'b1);

        // Normal fetch after all the flushes.
        fetch(64'h8000_0010, 64'h8000_0010, 0, 0, 64'h00000013_00400513, 2'b00,
              32'h0040_0513, 1'b0, 0, 3);

        // Reset while in DATA with the response arriving the same cycle.
        resp_en  = 1'b0;
        pc       = 64'h8000_0020;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        check("rstd_arvalid", {63'b0, mem_arvalid}, 64'd1);
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        check("rstd_rready", {63'b0, mem_rready}, 64'd1);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h12345678_9abcdef0;
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("rstd_inst", {32'b0, inst}, 64'd0);
        check("rstd_inst_valid", {63'b0, inst_valid}, 64'd0);
        check("rstd_fault", {63'b0, fetch_fault}, 64'd0);
        check("rstd_araddr", mem_araddr, 64'd0);
        check("rstd_arvalid_clr", {63'b0, mem_arvalid}, 64'd0);
        check("rstd_busy", {63'b0, busy}, 64'd0);
        check("rstd_rready_clr", {63'b0, mem_rready}, 64'd0);
        @(negedge clk);
        check("rstd_inst_valid_after", {63'b0, inst_valid}, 64'd0);
        resp_en = 1'b1;

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly upstream of the single-cycle RV64 core.
- Takes the core's current PC and issues an AXI-style read on the instruction bus. Holds the returned 32-bit instruction stable with a valid flag until the core consumes it.
- Core stalls (PC register write-enable low) while inst_valid is low; core pulses inst_ready on the cycle it retires the instruction.
- Also reports misaligned-PC and bus-error fetch faults, and discards in-flight responses on flush (redirect).

Parameters:
ADDR_W, 64, width of pc and mem_araddr
BUS_W, 64, read-data width; legal values 32 or 64

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pc  in  ADDR_W  fetch address from core PC register
pc_valid  in  1  pc holds a new address to fetch
flush  in  1  discard current fetch (redirect/exception)
inst  out  32  fetched instruction
inst_valid  out  1  inst/fetch_fault valid; held until inst_ready
inst_ready  in  1  core consumes inst this cycle
fetch_fault  out  1  qualifies inst_valid: fetch failed, inst is 0
mem_araddr  out  ADDR_W  read address, aligned to BUS_W/8 bytes
mem_arvalid  out  1  read address valid
mem_arready  in  1  bus accepts address
mem_rdata  in  BUS_W  read data
mem_rresp  in  2  0 = OKAY, nonzero = error
mem_rvalid  in  1  read data valid
mem_rready  out  1  IFU accepts read data
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at posedge): state = IDLE; inst = 0, inst_valid = 0, fetch_fault = 0, mem_araddr = 0, mem_arvalid = 0, mem_rready = 0, drop = 0, latched pc = 0. Reset overrides every other input and aborts any state, including mid-transaction; the bus is not waited on.
- States: IDLE, ADDR, DATA, HOLD. All outputs are registered except busy and mem_rready, which decode state.
- IDLE, pc_valid = 1 and flush = 0:
  - Latch pc.
  - If pc[1:0] != 0: go to HOLD with fetch_fault = 1, inst = 0, no bus access.
  - Else: mem_araddr = pc with low log2(BUS_W/8) bits cleared, mem_arvalid = 1, go to ADDR.
- IDLE, flush = 1: no request starts that cycle.
- ADDR: mem_arvalid and mem_araddr are held stable until mem_arready = 1. On that handshake: mem_arvalid = 0, go to DATA. mem_arvalid is never withdrawn before the handshake, even on flush. Flush here sets drop = 1.
- DATA: mem_rready = 1. On mem_rvalid = 1:
  - If drop = 1 or flush = 1: discard the response, clear drop, go to IDLE.
  - Else, BUS_W = 64: inst = latched_pc[2] ? rdata[63:32] : rdata[31:0]. BUS_W = 32: inst = rdata[31:0].
  - If rresp != 0: fetch_fault = 1 and inst = 0.
  - Set inst_valid = 1, go to HOLD.
- DATA, flush = 1 without rvalid: set drop = 1, stay in DATA.
- HOLD: inst_valid = 1; inst and fetch_fault are stable.
  - inst_ready = 1: inst_valid = 0, fetch_fault = 0, go to IDLE.
  - flush = 1: same as inst_ready = 1; the instruction is dropped.
  - flush and inst_ready together: go to IDLE, identical result.
- Minimum latency with zero-wait bus (arready and rvalid high): pc_valid at cycle 0, arvalid at cycle 1, rvalid accepted at cycle 2, inst_valid at cycle 3.
- Throughput: one instruction per 4 cycles minimum. A mandatory IDLE cycle follows each HOLD exit so the core PC can update.
- pc changes while busy are ignored; the latched pc is used.
- mem_rvalid in IDLE, ADDR or HOLD is ignored (rready = 0 there).
- One outstanding read maximum.

Test Plan:
- Zero-wait fetch: pc = 0x80000000, BUS_W = 64, rdata = 0x00100093_00000413 -> arvalid at cycle 1 with araddr = 0x80000000; inst = 0x00000413, inst_valid at cycle 3, held until inst_ready.
- Upper half and stalls: pc = 0x80000004, arready delayed 3 cycles, rvalid delayed 2 -> araddr = 0x80000000 held stable while arvalid is high; inst = 0x00100093.
- Misaligned: pc = 0x80000002 -> no arvalid; next cycle inst_valid = 1, fetch_fault = 1, inst = 0.
- Bus error: rresp = 2'b10 -> inst_valid = 1, fetch_fault = 1, inst = 0; both clear after inst_ready.
- Flush: flush in ADDR, then flush in DATA, then flush in HOLD -> arvalid still completes its handshake; responses are discarded; inst_valid never rises (or falls in HOLD); FSM returns to IDLE; next pc = 0x80000010 fetches normally.
- Reset mid-DATA with rvalid arriving the same cycle -> all outputs 0, state IDLE, response ignored.
